// File: rtl/prime_search_engine_pkg.sv
// Shared widths, divider timing and FSM state encoding for the prime search engine.
package prime_search_engine_pkg;

  localparam int WIDTH     = 20;
  localparam int CNT_WIDTH = 24;

  function automatic int div_latency(input int w);
    return w + 1;
  endfunction

  // Cycles from div_start to div_valid of the remainder divider.
  localparam int DIV_LATENCY = div_latency(WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_EVEN     = 3'd2,
    ST_DIVSTART = 3'd3,
    ST_DIVWAIT  = 3'd4,
    ST_NEXT     = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/prime_search_engine_if.sv
// Request/result bundle between the controller (master) and the prime search engine (slave).
interface prime_search_engine_if;
  import prime_search_engine_pkg::*;

  logic                 Start;
  logic                 Abort;
  logic [WIDTH-1:0]     Limit;
  logic                 Busy;
  logic                 Done;
  logic                 Found;
  logic [WIDTH-1:0]     LargestPrime;
  logic [CNT_WIDTH-1:0] TestCount;

  modport master (
    output Start, Abort, Limit,
    input  Busy, Done, Found, LargestPrime, TestCount
  );

  modport slave (
    input  Start, Abort, Limit,
    output Busy, Done, Found, LargestPrime, TestCount
  );

endinterface

// File: rtl/prime_search_engine_seq_remainder.sv
// Restoring divider returning only the remainder; one quotient bit per cycle,
// div_valid pulses DIV_LATENCY cycles after an accepted div_start.
module seq_remainder
  import prime_search_engine_pkg::*;
(
  input  logic             clk,
  input  logic             Reset,
  input  logic             div_start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             div_valid,
  output logic [WIDTH-1:0] Remainder
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ITER = CW'(DIV_LATENCY - 1);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic             r_valid;

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  // The difference only matters when it is smaller than the divisor, so WIDTH bits suffice.
  assign w_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[WIDTH-1:0] - r_dvs;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_busy) begin
        r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
        r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
        end
      end else if (div_start) begin
        r_busy <= 1'b1;
        r_cnt  <= ITER;
        r_dvd  <= Dividend;
        r_dvs  <= Divisor;
        r_rem  <= '0;
      end
    end
  end

  assign div_valid = r_valid;
  assign Remainder = r_rem;

endmodule

// File: rtl/prime_search_engine.sv
// Searches downward from Limit-1 for the largest prime using trial division by odd
// divisors d while d*d <= candidate; d*d is tracked incrementally in r_sq.
module prime_search_engine
  import prime_search_engine_pkg::*;
(
  input  logic                  clk,
  input  logic                  Reset,
  prime_search_engine_if.slave  bus
);

  state_t               r_state,  w_state_next;
  logic [WIDTH-1:0]     r_limit,  w_limit_next;
  logic [WIDTH-1:0]     r_cand,   w_cand_next;
  logic [WIDTH-1:0]     r_d,      w_d_next;
  logic [WIDTH+1:0]     r_sq,     w_sq_next;
  logic                 r_busy,   w_busy_next;
  logic                 r_done,   w_done_next;
  logic                 r_found,  w_found_next;
  logic [WIDTH-1:0]     r_prime,  w_prime_next;
  logic [CNT_WIDTH-1:0] r_count,  w_count_next;
  logic                 r_pending, w_pending_next;

  logic                 w_div_start;
  logic                 w_div_valid;
  logic [WIDTH-1:0]     w_rem;
  logic                 w_searching;

  seq_remainder u_div (
    .clk       (clk),
    .Reset     (Reset),
    .div_start (w_div_start),
    .Dividend  (r_cand),
    .Divisor   (r_d),
    .div_valid (w_div_valid),
    .Remainder (w_rem)
  );

  assign w_searching = (r_state != ST_IDLE) && (r_state != ST_DONE);

  always_comb begin
    w_state_next = r_state;
    w_limit_next = r_limit;
    w_cand_next  = r_cand;
    w_d_next     = r_d;
    w_sq_next    = r_sq;
    w_busy_next  = r_busy;
    w_done_next  = r_done;
    w_found_next = r_found;
    w_prime_next = r_prime;
    w_count_next = r_count;
    w_div_start  = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.Start) begin
          w_state_next = ST_LOAD;
          w_limit_next = bus.Limit;
          w_busy_next  = 1'b1;
          w_done_next  = 1'b0;
          w_count_next = '0;
        end
      end
      ST_LOAD: begin
        if (r_limit <= WIDTH'(2)) begin
          w_state_next = ST_DONE;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
          w_found_next = 1'b0;
          w_prime_next = '0;
        end else begin
          w_cand_next  = r_limit - WIDTH'(1);
          w_state_next = ST_EVEN;
        end
      end
      ST_EVEN: begin
        if (r_cand == WIDTH'(2)) begin
          w_state_next = ST_DONE;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
          w_found_next = 1'b1;
          w_prime_next = r_cand;
        end else if (!r_cand[0]) begin
          w_state_next = ST_NEXT;
        end else begin
          w_d_next     = WIDTH'(3);
          w_sq_next    = (WIDTH+2)'(9);
          w_state_next = ST_DIVSTART;
        end
      end
      ST_DIVSTART: begin
        if (r_sq > {2'b00, r_cand}) begin
          w_state_next = ST_DONE;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
          w_found_next = 1'b1;
          w_prime_next = r_cand;
        end else if (!r_pending) begin
          // Held off while a division orphaned by an abort is still draining.
          w_div_start  = 1'b1;
          w_state_next = ST_DIVWAIT;
          if (r_count != '1) begin
            w_count_next = r_count + CNT_WIDTH'(1);
          end
        end
      end
      ST_DIVWAIT: begin
        if (w_div_valid) begin
          if (w_rem == '0) begin
            w_state_next = ST_NEXT;
          end else begin
            w_d_next     = r_d + WIDTH'(2);
            w_sq_next    = r_sq + {r_d, 2'b00} + (WIDTH+2)'(4);
            w_state_next = ST_DIVSTART;
          end
        end
      end
      ST_NEXT: begin
        w_cand_next  = r_cand - WIDTH'(1);
        w_state_next = ST_EVEN;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (bus.Abort && w_searching) begin
      w_state_next = ST_DONE;
      w_busy_next  = 1'b0;
      w_done_next  = 1'b1;
      w_found_next = 1'b0;
      w_prime_next = '0;
      w_count_next = r_count;
      w_div_start  = 1'b0;
    end

    w_pending_next = r_pending;
    if (w_div_valid) begin
      w_pending_next = 1'b0;
    end
    if (w_div_start) begin
      w_pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_limit   <= '0;
      r_cand    <= '0;
      r_d       <= '0;
      r_sq      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_found   <= 1'b0;
      r_prime   <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_limit   <= w_limit_next;
      r_cand    <= w_cand_next;
      r_d       <= w_d_next;
      r_sq      <= w_sq_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_found   <= w_found_next;
      r_prime   <= w_prime_next;
      r_count   <= w_count_next;
      r_pending <= w_pending_next;
    end
  end

  assign bus.Busy         = r_busy;
  assign bus.Done         = r_done;
  assign bus.Found        = r_found;
  assign bus.LargestPrime = r_prime;
  assign bus.TestCount    = r_count;

endmodule

// File: tb/tb_prime_search_engine.sv
// Self-checking bench: directed and random limits compared against a plain-arithmetic
// trial-division model of the search.
module tb_prime_search_engine;
  import prime_search_engine_pkg::*;

  localparam int BOUND = 40000;

  logic clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  prime_search_engine_if bus();

  prime_search_engine dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Largest prime below limit, plus the number of trial divisions d*d<=cand needed to find it.
  function automatic int model_search(input int limit, output int divs);
    bit comp;
    divs = 0;
    if (limit <= 2) return 0;
    for (int cand = limit - 1; cand > 2; cand--) begin
      if (cand % 2 == 0) continue;
      comp = 1'b0;
      for (int d = 3; d * d <= cand; d += 2) begin
        divs++;
        if (cand % d == 0) begin
          comp = 1'b1;
          break;
        end
      end
      if (!comp) return cand;
    end
    return 2;
  endfunction

  task automatic wait_done(inout int cyc, output bit tmo, inout bit busy_bad);
    while (!bus.Done && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      if (!bus.Done && !bus.Busy) busy_bad = 1'b1;
    end
    tmo = !bus.Done;
    if (bus.Done && bus.Busy) busy_bad = 1'b1;
  endtask

  task automatic pulse_start(input int limit);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Limit = WIDTH'(limit);
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic test_search(input string name, input int limit, output int cyc);
    bit tmo;
    bit busy_bad;
    int exp_p;
    int divs;
    logic [WIDTH-1:0]     want_p;
    logic [CNT_WIDTH-1:0] want_c;
    exp_p  = model_search(limit, divs);
    want_p = exp_p[WIDTH-1:0];
    want_c = divs[CNT_WIDTH-1:0];
    pulse_start(limit);
    cyc = 1;
    busy_bad = !(bus.Busy === 1'b1 && bus.Done === 1'b0);
    wait_done(cyc, tmo, busy_bad);
    total++;
    if (tmo) begin
      bad++;
      $display("FAIL %s_timeout: done=%0b required 1 within %0d cycles", name, bus.Done, BOUND);
    end
    total++;
    if (busy_bad) begin
      bad++;
      $display("FAIL %s_busy: busy/done sequencing wrong, busy=%0b done=%0b at end", name, bus.Busy, bus.Done);
    end
    total++;
    if (bus.Found !== (exp_p != 0)) begin
      bad++;
      $display("FAIL %s_found: got %0b required %0b", name, bus.Found, (exp_p != 0));
    end
    total++;
    if (bus.LargestPrime !== want_p) begin
      bad++;
      $display("FAIL %s_prime: got %0d required %0d", name, bus.LargestPrime, want_p);
    end
    total++;
    if (bus.TestCount !== want_c) begin
      bad++;
      $display("FAIL %s_count: got %0d required %0d", name, bus.TestCount, want_c);
    end
    $display("txn %s limit=%0d prime=%0d count=%0d cycles=%0d", name, limit, bus.LargestPrime, bus.TestCount, cyc);
  endtask

  task automatic test_reset();
    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    bus.Limit = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.Busy, bus.Done, bus.Found, bus.LargestPrime, bus.TestCount} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%0b done=%0b found=%0b prime=%0d count=%0d required all 0",
               bus.Busy, bus.Done, bus.Found, bus.LargestPrime, bus.TestCount);
    end
    Reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.Busy, bus.Done} !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%0b done=%0b required 0 0", bus.Busy, bus.Done);
    end
    $display("txn reset released");
  endtask

  task automatic test_small_limits();
    int cyc;
    test_search("lim2", 2, cyc);
    total++;
    if (cyc > 2) begin
      bad++;
      $display("FAIL lim2_latency: got %0d cycles required <= 2", cyc);
    end
    test_search("lim0", 0, cyc);
    total++;
    if (cyc > 2) begin
      bad++;
      $display("FAIL lim0_latency: got %0d cycles required <= 2", cyc);
    end
    test_search("lim3", 3, cyc);
  endtask

  task automatic test_boundaries();
    int cyc;
    test_search("lim100", 100, cyc);
    test_search("lim50", 50, cyc);
    test_search("lim26", 26, cyc);
  endtask

  task automatic test_large();
    int cyc;
    test_search("lim1000000", 1000000, cyc);
  endtask

  task automatic test_ignore_start();
    int  cyc;
    bit  tmo;
    bit  busy_bad;
    int  divs;
    int  exp_p;
    logic [WIDTH-1:0]     want_p;
    logic [CNT_WIDTH-1:0] want_c;
    exp_p  = model_search(1000000, divs);
    want_p = exp_p[WIDTH-1:0];
    want_c = divs[CNT_WIDTH-1:0];
    pulse_start(1000000);
    cyc = 1;
    busy_bad = 1'b0;
    repeat (100) @(negedge clk);
    cyc += 100;
    pulse_start(10);
    cyc += 2;
    wait_done(cyc, tmo, busy_bad);
    total++;
    if (tmo || bus.LargestPrime !== want_p) begin
      bad++;
      $display("FAIL ignore_start_prime: got %0d (done=%0b) required %0d", bus.LargestPrime, bus.Done, want_p);
    end
    total++;
    if (bus.TestCount !== want_c) begin
      bad++;
      $display("FAIL ignore_start_count: got %0d required %0d", bus.TestCount, want_c);
    end
    $display("txn ignored_start limit=1000000 prime=%0d count=%0d", bus.LargestPrime, bus.TestCount);
    test_search("after_ignored", 10, cyc);
  endtask

  task automatic test_reset_mid();
    int cyc;
    pulse_start(1000000);
    repeat (60) @(negedge clk);
    total++;
    if (bus.Busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_busy: got %0b required 1 before reset", bus.Busy);
    end
    Reset = 1'b1;
    #1;
    total++;
    if ({bus.Busy, bus.Done, bus.Found, bus.LargestPrime, bus.TestCount} !== '0) begin
      bad++;
      $display("FAIL reset_mid_async: busy=%0b done=%0b found=%0b prime=%0d count=%0d required all 0",
               bus.Busy, bus.Done, bus.Found, bus.LargestPrime, bus.TestCount);
    end
    $display("txn reset mid-search");
    @(negedge clk);
    Reset = 1'b0;
    test_search("post_reset", 20, cyc);
  endtask

  task automatic test_abort();
    int cyc;
    bit tmo;
    bit busy_bad;
    pulse_start(1000000);
    repeat (70) @(negedge clk);
    bus.Abort = 1'b1;
    @(negedge clk);
    bus.Abort = 1'b0;
    total++;
    if ({bus.Done, bus.Found, bus.Busy} !== 3'b100 || bus.LargestPrime !== '0) begin
      bad++;
      $display("FAIL abort_result: done=%0b found=%0b busy=%0b prime=%0d required 1 0 0 0",
               bus.Done, bus.Found, bus.Busy, bus.LargestPrime);
    end
    $display("txn abort mid-search done=%0b found=%0b", bus.Done, bus.Found);
    test_search("after_abort", 100, cyc);
    bus.Abort = 1'b1;
    @(negedge clk);
    bus.Abort = 1'b0;
    @(negedge clk);
    total++;
    if (bus.Done !== 1'b1 || bus.LargestPrime !== WIDTH'(97)) begin
      bad++;
      $display("FAIL abort_in_done: done=%0b prime=%0d required 1 97", bus.Done, bus.LargestPrime);
    end
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Abort = 1'b1;
    bus.Limit = WIDTH'(26);
    @(negedge clk);
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    cyc = 1;
    busy_bad = !(bus.Busy === 1'b1 && bus.Done === 1'b0);
    wait_done(cyc, tmo, busy_bad);
    total++;
    if (tmo || busy_bad || bus.LargestPrime !== WIDTH'(23)) begin
      bad++;
      $display("FAIL start_beats_abort: prime=%0d done=%0b busy_bad=%0b required 23 1 0",
               bus.LargestPrime, bus.Done, busy_bad);
    end
    $display("txn start+abort limit=26 prime=%0d", bus.LargestPrime);
  endtask

  task automatic test_random();
    int cyc;
    int limit;
    for (int i = 0; i < 6; i++) begin
      limit = int'($urandom_range(3, 20000));
      test_search("random", limit, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_small_limits();
    test_boundaries();
    test_large();
    test_ignore_start();
    test_reset_mid();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
